accum48_dump_round: RTL

//  Integrate-and-dump back end for the 48-bit DSP48E accumulator (accum48).

---
 rtl/dsp48e_pkg.sv | 16 +
 rtl/sat_round_shift.sv | 51 +++++
 rtl/accum48_dump_round.sv | 111 +++++++++++
 3 files changed

// File: rtl/dsp48e_pkg.sv
// Shared widths, saturation limits and the result record used by the
// accumulator dump/round back end.
package dsp48e_pkg;
  localparam int ACC_W  = 48;
  localparam int OUT_W  = 24;
  localparam int SH_W   = 6;
  localparam int SH_MAX = 47;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } result_t;
endpackage

// File: rtl/sat_round_shift.sv
// Round-half-up is added before the S1 register; the shift and saturate
// stage is combinational off that register.
module sat_round_shift
  import dsp48e_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [SH_W-1:0]  i_sh,
  output logic             o_vld,
  output result_t          o_res
);
  logic [ACC_W:0]        w_rnd;
  logic [ACC_W:0]        w_sum;
  logic [SH_W-1:0]       w_shm1;
  logic signed [ACC_W:0] w_shr;
  logic                  w_ovf;
  logic signed [ACC_W:0] r_sum;
  logic [SH_W-1:0]       r_sh;
  logic                  r_vld;

  always_comb begin
    w_shm1 = i_sh - SH_W'(1);
    w_rnd  = (i_sh == '0) ? '0 : ((ACC_W+1)'(1) << w_shm1);
    w_sum  = {i_acc[ACC_W-1], i_acc} + w_rnd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_sum <= '0;
      r_sh  <= '0;
    end else begin
      r_vld <= i_ld;
      if (i_ld) begin
        r_sum <= w_sum;
        r_sh  <= i_sh;
      end
    end
  end

  // In range only when every bit above the output sign bit matches it.
  always_comb begin
    w_shr      = r_sum >>> r_sh;
    w_ovf      = ~((&w_shr[ACC_W:OUT_W-1]) | ~(|w_shr[ACC_W:OUT_W-1]));
    o_res.sat  = w_ovf;
    o_res.data = w_ovf ? (w_shr[ACC_W] ? SAT_MIN : SAT_MAX) : w_shr[OUT_W-1:0];
    o_vld      = r_vld;
  end
endmodule

// File: rtl/accum48_dump_round.sv
// Integrate-and-dump back end: frame counter, accumulator clear pulse,
// round/shift/saturate datapath and a 2-entry valid/ready output queue.
module accum48_dump_round
  import dsp48e_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ACC_W-1:0] ACC_IN,
  input  logic             ACC_VLD,
  input  logic [CNT_W-1:0] DUMP_LEN,
  input  logic [SH_W-1:0]  SHIFT,
  output logic             ACC_CLR,
  output logic [OUT_W-1:0] DOUT,
  output logic             DOUT_VLD,
  input  logic             DOUT_RDY,
  output logic             SAT,
  output logic             OVR
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [SH_W-1:0]  r_sh;
  logic             r_clr;
  result_t          r_q0;
  result_t          r_q1;
  logic [1:0]       r_qn;
  logic             r_ovr;

  logic [CNT_W-1:0] w_len_in;
  logic [SH_W-1:0]  w_sh_in;
  logic [CNT_W-1:0] w_len;
  logic [SH_W-1:0]  w_sh;
  logic             w_dump;
  logic             w_push;
  logic             w_pop;
  result_t          w_res;

  // Frame parameters come straight from the ports on the first sample of a
  // frame, so a one-sample frame needs no extra cycle to latch them.
  always_comb begin
    w_len_in = (DUMP_LEN == '0) ? CNT_W'(1) : DUMP_LEN;
    w_sh_in  = (SHIFT > SH_W'(SH_MAX)) ? SH_W'(SH_MAX) : SHIFT;
    w_len    = (r_cnt == '0) ? w_len_in : r_len;
    w_sh     = (r_cnt == '0) ? w_sh_in : r_sh;
    w_dump   = ACC_VLD & (r_cnt == w_len - CNT_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_len <= '0;
      r_sh  <= '0;
      r_clr <= 1'b0;
    end else begin
      r_clr <= w_dump;
      if (ACC_VLD) begin
        if (r_cnt == '0) begin
          r_len <= w_len_in;
          r_sh  <= w_sh_in;
        end
        r_cnt <= w_dump ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  sat_round_shift u_srs (
    .clk   (CLK),
    .rst   (RST),
    .i_ld  (w_dump),
    .i_acc (ACC_IN),
    .i_sh  (w_sh),
    .o_vld (w_push),
    .o_res (w_res)
  );

  assign w_pop = (r_qn != 2'd0) & DOUT_RDY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_qn  <= 2'd0;
      r_ovr <= 1'b0;
    end else if (w_pop) begin
      if (w_push) begin
        if (r_qn == 2'd2) begin
          r_q0 <= r_q1;
          r_q1 <= w_res;
        end else begin
          r_q0 <= w_res;
        end
      end else begin
        r_q0 <= r_q1;
        r_qn <= r_qn - 2'd1;
      end
    end else if (w_push) begin
      case (r_qn)
        2'd0:    begin r_q0 <= w_res; r_qn <= 2'd1; end
        2'd1:    begin r_q1 <= w_res; r_qn <= 2'd2; end
        default: r_ovr <= 1'b1;
      endcase
    end
  end

  assign ACC_CLR  = r_clr;
  assign DOUT     = r_q0.data;
  assign SAT      = r_q0.sat;
  assign DOUT_VLD = (r_qn != 2'd0);
  assign OVR      = r_ovr;
endmodule
